// File: rtl/nasti_mem_responder.sv
// nasti_mem_responder: AXI4 (NASTI) responder backed by an internal byte-strobed RAM.
// Independent write (AW/W/B) and read (AR/R) engines with one burst in flight per direction.
// All bursts are treated as INCR with full-width beats; size/burst fields are ignored.
// Optional feature macro NASTI_MEM_RESP_ERR_EN: beats at or above MEM_BYTES are dropped
// (write) or return zero data (read) with DECERR. Without it, addresses wrap modulo MEM_BYTES.
module nasti_mem_responder #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int MEM_BYTES  = 65536,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    slv_aw_valid,
   output logic                    slv_aw_ready,
   input  logic [ADDR_WIDTH-1:0]   slv_aw_addr,
   input  logic [7:0]              slv_aw_len,
   input  logic [2:0]              slv_aw_size,
   input  logic [1:0]              slv_aw_burst,
   input  logic [ID_WIDTH-1:0]     slv_aw_id,
   input  logic                    slv_w_valid,
   output logic                    slv_w_ready,
   input  logic [DATA_WIDTH-1:0]   slv_w_data,
   input  logic [DATA_WIDTH/8-1:0] slv_w_strb,
   input  logic                    slv_w_last,
   output logic                    slv_b_valid,
   input  logic                    slv_b_ready,
   output logic [ID_WIDTH-1:0]     slv_b_id,
   output logic [1:0]              slv_b_resp,
   input  logic                    slv_ar_valid,
   output logic                    slv_ar_ready,
   input  logic [ADDR_WIDTH-1:0]   slv_ar_addr,
   input  logic [7:0]              slv_ar_len,
   input  logic [2:0]              slv_ar_size,
   input  logic [1:0]              slv_ar_burst,
   input  logic [ID_WIDTH-1:0]     slv_ar_id,
   output logic                    slv_r_valid,
   input  logic                    slv_r_ready,
   output logic [ID_WIDTH-1:0]     slv_r_id,
   output logic [DATA_WIDTH-1:0]   slv_r_data,
   output logic [1:0]              slv_r_resp,
   output logic                    slv_r_last
);

   localparam int BEAT    = DATA_WIDTH / 8;
   localparam int BEAT_LG = $clog2(BEAT);
   localparam int WORDS   = MEM_BYTES / BEAT;
   localparam int IDX_W   = $clog2(WORDS);
   localparam logic [ADDR_WIDTH-1:0] BEAT_INC   = ADDR_WIDTH'(BEAT);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BEAT - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_len;
   logic [8:0]            w_cnt;     // beats accepted so far, saturating
   logic                  w_dec;     // an earlier beat of this burst was out of range
   logic [1:0]            w_resp_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;    // address of the next beat to fetch
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;     // index of the beat currently presented
   logic [7:0]            r_cnt_nxt;
   logic                  aw_hs, w_hs, ar_hs;
   logic                  w_oob, r_oob;
   logic [IDX_W-1:0]      w_idx, r_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_ok;

   assign aw_hs = slv_aw_valid & slv_aw_ready;
   assign w_hs  = slv_w_valid & slv_w_ready;
   assign ar_hs = slv_ar_valid & slv_ar_ready;

   assign w_idx = w_addr[BEAT_LG +: IDX_W];
   assign r_idx = r_addr[BEAT_LG +: IDX_W];

`ifdef NASTI_MEM_RESP_ERR_EN
   assign w_oob = (w_addr >= ADDR_WIDTH'(MEM_BYTES));
   assign r_oob = (r_addr >= ADDR_WIDTH'(MEM_BYTES));
`else
   assign w_oob = 1'b0;
   assign r_oob = 1'b0;
`endif

   assign rd_word   = r_oob ? '0 : mem[r_idx];
   assign r_cnt_nxt = slv_r_valid ? r_cnt + 8'd1 : r_cnt;
   assign unused_ok = ^{slv_aw_size, slv_aw_burst, slv_ar_size, slv_ar_burst};

   // Write FSM state register
   always_ff @(posedge aclk) begin
      if (areset) w_state <= W_IDLE;
      else        w_state <= w_state_nxt;
   end

   // Write FSM next-state: address, data beats until w_last, then hold B until accepted
   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (slv_aw_valid)               w_state_nxt = W_DATA;
         W_DATA:  if (slv_w_valid && slv_w_last)  w_state_nxt = W_RESP;
         W_RESP:  if (slv_b_ready)                w_state_nxt = W_IDLE;
         default:                                 w_state_nxt = W_IDLE;
      endcase
   end

   // Write FSM outputs are pure decodes of the state
   always_comb begin
      slv_aw_ready = (w_state == W_IDLE);
      slv_w_ready  = (w_state == W_DATA);
      slv_b_valid  = (w_state == W_RESP);
   end

   // Length mismatch outranks a decode error on the final response
   always_comb begin
      if (w_cnt != {1'b0, w_len}) w_resp_nxt = RESP_SLVERR;
      else if (w_dec || w_oob)    w_resp_nxt = RESP_DECERR;
      else                        w_resp_nxt = RESP_OKAY;
   end

   // Write burst bookkeeping; the response code is captured on the last beat
   always_ff @(posedge aclk) begin
      if (areset) begin
         slv_b_resp <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            w_addr   <= slv_aw_addr & ALIGN_MASK;
            w_len    <= slv_aw_len;
            slv_b_id <= slv_aw_id;
            w_cnt    <= '0;
            w_dec    <= 1'b0;
         end
         if (w_hs) begin
            w_addr <= w_addr + BEAT_INC;
            if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
            w_dec <= w_dec | w_oob;
            if (slv_w_last) slv_b_resp <= w_resp_nxt;
         end
      end
   end

   // Byte-strobed memory write; out-of-range beats never touch the array
   always_ff @(posedge aclk) begin
      if (!areset && w_hs && !w_oob) begin
         for (int b = 0; b < BEAT; b++) begin
            if (slv_w_strb[b]) mem[w_idx][8*b +: 8] <= slv_w_data[8*b +: 8];
         end
      end
   end

   // Read FSM state register
   always_ff @(posedge aclk) begin
      if (areset) r_state <= R_IDLE;
      else        r_state <= r_state_nxt;
   end

   // Read FSM next-state: idle until AR, stream until the last beat is accepted
   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (slv_ar_valid) r_state_nxt = R_DATA;
         R_DATA:  if (slv_r_valid && slv_r_ready && slv_r_last) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read FSM output decode
   always_comb begin
      slv_ar_ready = (r_state == R_IDLE);
   end

   // R channel registers: first fetch fills the empty slot, later fetches ride on each accepted
   // beat so a held-high r_ready sees one beat per cycle; a stalled beat is left untouched.
   // The array is sampled before this edge's write lands, giving read-before-write.
   always_ff @(posedge aclk) begin
      if (areset) begin
         slv_r_valid <= 1'b0;
         slv_r_last  <= 1'b0;
         slv_r_resp  <= RESP_OKAY;
      end else if (ar_hs) begin
         r_addr   <= slv_ar_addr & ALIGN_MASK;
         r_len    <= slv_ar_len;
         slv_r_id <= slv_ar_id;
         r_cnt    <= '0;
      end else if (r_state == R_DATA) begin
         if (!slv_r_valid || (slv_r_ready && !slv_r_last)) begin
            slv_r_valid <= 1'b1;
            slv_r_data  <= rd_word;
            slv_r_resp  <= r_oob ? RESP_DECERR : RESP_OKAY;
            slv_r_last  <= (r_cnt_nxt == r_len);
            r_cnt       <= r_cnt_nxt;
            r_addr      <= r_addr + BEAT_INC;
         end else if (slv_r_ready) begin
            slv_r_valid <= 1'b0;
            slv_r_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nasti_mem_responder.sv
// tb_nasti_mem_responder: directed bench for nasti_mem_responder with a word-array memory
// model, expected-beat queues for R and B checked every cycle, and literal spot checks.
module tb_nasti_mem_responder;

   localparam int AW    = 64;
   localparam int DW    = 64;
   localparam int MB    = 65536;
   localparam int IW    = 4;
   localparam int WORDS = MB / 8;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          slv_aw_valid, slv_aw_ready;
   logic [AW-1:0] slv_aw_addr;
   logic [7:0]    slv_aw_len;
   logic [2:0]    slv_aw_size;
   logic [1:0]    slv_aw_burst;
   logic [IW-1:0] slv_aw_id;
   logic          slv_w_valid, slv_w_ready, slv_w_last;
   logic [DW-1:0] slv_w_data;
   logic [7:0]    slv_w_strb;
   logic          slv_b_valid, slv_b_ready;
   logic [IW-1:0] slv_b_id;
   logic [1:0]    slv_b_resp;
   logic          slv_ar_valid, slv_ar_ready;
   logic [AW-1:0] slv_ar_addr;
   logic [7:0]    slv_ar_len;
   logic [2:0]    slv_ar_size;
   logic [1:0]    slv_ar_burst;
   logic [IW-1:0] slv_ar_id;
   logic          slv_r_valid, slv_r_ready, slv_r_last;
   logic [IW-1:0] slv_r_id;
   logic [DW-1:0] slv_r_data;
   logic [1:0]    slv_r_resp;

   nasti_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB), .ID_WIDTH(IW)) dut (
      .aclk(aclk), .areset(areset),
      .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready), .slv_aw_addr(slv_aw_addr),
      .slv_aw_len(slv_aw_len), .slv_aw_size(slv_aw_size), .slv_aw_burst(slv_aw_burst),
      .slv_aw_id(slv_aw_id),
      .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready), .slv_w_data(slv_w_data),
      .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last),
      .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready), .slv_b_id(slv_b_id),
      .slv_b_resp(slv_b_resp),
      .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready), .slv_ar_addr(slv_ar_addr),
      .slv_ar_len(slv_ar_len), .slv_ar_size(slv_ar_size), .slv_ar_burst(slv_ar_burst),
      .slv_ar_id(slv_ar_id),
      .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready), .slv_r_id(slv_r_id),
      .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last)
   );

   always #5 aclk = ~aclk;

   int          n_vec = 0;
   int          n_err = 0;
   int          r_pops = 0;
   logic [63:0] mdl [WORDS];
   logic [70:0] exp_r [$];   // {data, last, id, resp}
   logic [5:0]  exp_b [$];   // {id, resp}
   logic [63:0] wd_q [$];
   logic [7:0]  ws_q [$];
   logic [63:0] last_rdata;
   logic [1:0]  last_rresp;
   logic        last_rlast;
   logic [3:0]  last_rid;
   logic [5:0]  last_b;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every cycle outside reset: any valid R or B beat must match the head of its queue
   always @(negedge aclk) begin
      if (!areset) begin
         if (slv_r_valid) begin
            if (exp_r.size() == 0) begin
               chk("r_unexpected", 80'(slv_r_valid), 80'(0));
            end else begin
               chk("r_beat", 80'({slv_r_data, slv_r_last, slv_r_id, slv_r_resp}), 80'(exp_r[0]));
               if (slv_r_ready) begin
                  last_rdata = slv_r_data;
                  last_rresp = slv_r_resp;
                  last_rlast = slv_r_last;
                  last_rid   = slv_r_id;
                  void'(exp_r.pop_front());
                  r_pops++;
               end
            end
         end
         if (slv_b_valid) begin
            if (exp_b.size() == 0) begin
               chk("b_unexpected", 80'(slv_b_valid), 80'(0));
            end else begin
               chk("b_resp", 80'({slv_b_id, slv_b_resp}), 80'(exp_b[0]));
               if (slv_b_ready) begin
                  last_b = {slv_b_id, slv_b_resp};
                  void'(exp_b.pop_front());
               end
            end
         end
      end
   end

   task automatic wait_hs(input int ch, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge aclk);
         case (ch)
            0:       ok = slv_aw_ready;
            1:       ok = slv_w_ready;
            default: ok = slv_ar_ready;
         endcase
         @(posedge aclk);
         #1;
      end
      if (!ok) chk("hs_timeout", 80'(ok), 80'(1));
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id,
                           input int nbeats, input logic [1:0] burst);
      logic [63:0] wa;
      bit          ok;
      bit          dec;
      int          c;
      dec = 1'b0;
      wa  = addr & ~64'h7;
      slv_aw_addr = addr; slv_aw_len = len; slv_aw_id = id; slv_aw_burst = burst;
      slv_aw_valid = 1'b1;
      wait_hs(0, ok);
      slv_aw_valid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         logic [63:0] ba;
         int          idx;
         bit          drop;
         slv_w_data = wd_q[i]; slv_w_strb = ws_q[i]; slv_w_last = (i == nbeats - 1);
         slv_w_valid = 1'b1;
         wait_hs(1, ok);
         ba   = wa + 64'(i) * 64'd8;
         idx  = int'((ba >> 3) % 64'(WORDS));
         drop = 1'b0;
`ifdef NASTI_MEM_RESP_ERR_EN
         if (ba >= 64'(MB)) begin drop = 1'b1; dec = 1'b1; end
`endif
         if (!drop) begin
            for (int b = 0; b < 8; b++) begin
               if (ws_q[i][b]) mdl[idx][8*b +: 8] = wd_q[i][8*b +: 8];
            end
         end
      end
      slv_w_valid = 1'b0; slv_w_last = 1'b0;
      exp_b.push_back({id, (nbeats == int'(len) + 1) ? (dec ? 2'b11 : 2'b00) : 2'b10});
      c = 0;
      while (exp_b.size() != 0 && c < 100) begin @(posedge aclk); c++; end
      #1;
      if (exp_b.size() != 0) begin
         chk("b_timeout", 80'(exp_b.size()), 80'(0));
         exp_b.delete();
      end
   endtask

   task automatic rd_issue(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
      logic [63:0] wa;
      bit          ok;
      wa = addr & ~64'h7;
      for (int i = 0; i <= int'(len); i++) begin
         logic [63:0] ba;
         logic [63:0] d;
         logic [1:0]  rs;
         ba = wa + 64'(i) * 64'd8;
         d  = mdl[int'((ba >> 3) % 64'(WORDS))];
         rs = 2'b00;
`ifdef NASTI_MEM_RESP_ERR_EN
         if (ba >= 64'(MB)) begin d = '0; rs = 2'b11; end
`endif
         exp_r.push_back({d, (i == int'(len)), id, rs});
      end
      slv_ar_addr = addr; slv_ar_len = len; slv_ar_id = id; slv_ar_valid = 1'b1;
      wait_hs(2, ok);
      slv_ar_valid = 1'b0;
   endtask

   // With r_ready held high a burst of len+1 beats drains len+2 cycles after AR
   task automatic rd_wait(input bit toggle, input int len);
      int c;
      c = 0;
      while (exp_r.size() != 0 && c < 3000) begin
         @(posedge aclk);
         c++;
         if (toggle) begin #1; slv_r_ready = ~slv_r_ready; end
      end
      #1;
      if (exp_r.size() != 0) begin
         chk("r_timeout", 80'(exp_r.size()), 80'(0));
         exp_r.delete();
      end else if (!toggle) begin
         chk("r_no_bubble", 80'(c), 80'(len + 2));
      end
      slv_r_ready = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int c;
      slv_aw_valid = 0; slv_aw_addr = '0; slv_aw_len = '0; slv_aw_size = 3'd3; slv_aw_burst = 2'b01;
      slv_aw_id = '0; slv_w_valid = 0; slv_w_data = '0; slv_w_strb = '0; slv_w_last = 0;
      slv_b_ready = 1; slv_ar_valid = 0; slv_ar_addr = '0; slv_ar_len = '0; slv_ar_size = 3'd3;
      slv_ar_burst = 2'b01; slv_ar_id = '0; slv_r_ready = 1;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_aw_ready", 80'(slv_aw_ready), 80'(1));
      chk("rst_ar_ready", 80'(slv_ar_ready), 80'(1));
      chk("rst_w_ready",  80'(slv_w_ready),  80'(0));
      chk("rst_b_valid",  80'(slv_b_valid),  80'(0));
      chk("rst_r_valid",  80'(slv_r_valid),  80'(0));
      chk("rst_r_last",   80'(slv_r_last),   80'(0));
      chk("rst_b_resp",   80'(slv_b_resp),   80'(0));
      chk("rst_r_resp",   80'(slv_r_resp),   80'(0));
      @(posedge aclk); #1 areset = 0;

      // single beat write and readback
      wd_q = '{64'hDEADBEEF_CAFEF00D}; ws_q = '{8'hFF};
      do_write(64'h100, 8'd0, 4'd3, 1, 2'b01);
      chk("single_b", 80'(last_b), 80'({4'd3, 2'b00}));
      rd_issue(64'h100, 8'd0, 4'd3);
      rd_wait(0, 0);
      chk("single_data", 80'(last_rdata), 80'(64'hDEADBEEF_CAFEF00D));
      chk("single_last_id", 80'({last_rlast, last_rid}), 80'({1'b1, 4'd3}));

      // 256-beat burst (FIXED encoding still increments), read back under r_ready toggling
      wd_q.delete(); ws_q.delete();
      for (int i = 0; i < 256; i++) begin wd_q.push_back(64'(i)); ws_q.push_back(8'hFF); end
      do_write(64'h0, 8'd255, 4'd5, 256, 2'b00);
      chk("burst_b", 80'(last_b), 80'({4'd5, 2'b00}));
      chk("burst_model", 80'(mdl[200]), 80'(200));
      rd_issue(64'h0, 8'd255, 4'd6);
      rd_wait(1, 255);
      chk("burst_last_beat", 80'({last_rdata, last_rlast}), 80'({64'd255, 1'b1}));

      // byte strobes
      wd_q = '{64'hFFFFFFFF_FFFFFFFF}; ws_q = '{8'hFF};
      do_write(64'h40, 8'd0, 4'd1, 1, 2'b01);
      wd_q = '{64'h0}; ws_q = '{8'h0F};
      do_write(64'h40, 8'd0, 4'd1, 1, 2'b10);
      chk("strb_model", 80'(mdl[8]), 80'(64'hFFFFFFFF_00000000));
      rd_issue(64'h40, 8'd0, 4'd2);
      rd_wait(0, 0);
      chk("strb_data", 80'(last_rdata), 80'(64'hFFFFFFFF_00000000));

      // short burst: len=3, w_last on the third beat
      wd_q = '{64'hA0, 64'hA1, 64'hA2}; ws_q = '{8'hFF, 8'hFF, 8'hFF};
      do_write(64'h300, 8'd3, 4'd7, 3, 2'b01);
      chk("short_slverr", 80'(last_b), 80'({4'd7, 2'b10}));

      // long burst: len=1 but three beats, all written
      wd_q = '{64'hB0, 64'hB1, 64'hB2};
      do_write(64'h404, 8'd1, 4'd8, 3, 2'b01);
      chk("long_slverr", 80'(last_b), 80'({4'd8, 2'b10}));
      rd_issue(64'h400, 8'd2, 4'd8);
      rd_wait(0, 2);
      chk("long_third", 80'(last_rdata), 80'(64'hB2));

      // same-cycle read and write to one word returns the old contents
      wd_q = '{64'h1111_2222_3333_4444}; ws_q = '{8'hFF};
      fork
         do_write(64'h100, 8'd0, 4'd9, 1, 2'b01);
         begin rd_issue(64'h100, 8'd0, 4'd10); rd_wait(0, 0); end
      join
      chk("rbw_old", 80'(last_rdata), 80'(64'd32));
      rd_issue(64'h100, 8'd0, 4'd10);
      rd_wait(0, 0);
      chk("rbw_new", 80'(last_rdata), 80'(64'h1111_2222_3333_4444));

      // reset while beat 5 of a 16-beat read is on the bus
      base = r_pops;
      rd_issue(64'h0, 8'd15, 4'd4);
      c = 0;
      while (r_pops < base + 5 && c < 100) begin @(posedge aclk); c++; end
      chk("mid_reset_reach", 80'(r_pops - base), 80'(5));
      #1 areset = 1;
      @(posedge aclk);
      exp_r.delete();
      @(negedge aclk);
      chk("mid_reset_rvalid", 80'(slv_r_valid), 80'(0));
      chk("mid_reset_arready", 80'(slv_ar_ready), 80'(1));
      @(posedge aclk); #1 areset = 0;
      rd_issue(64'h40, 8'd3, 4'd4);
      rd_wait(0, 3);
      chk("post_reset_last", 80'({last_rdata, last_rlast}), 80'({64'd11, 1'b1}));

      // read at MEM_BYTES: wraps to word 0 or returns DECERR
      wd_q = '{64'h12345678_9ABCDEF0}; ws_q = '{8'hFF};
      do_write(64'h0, 8'd0, 4'd1, 1, 2'b01);
      rd_issue(64'(MB), 8'd0, 4'd2);
      rd_wait(0, 0);
`ifdef NASTI_MEM_RESP_ERR_EN
      chk("oob_read", 80'({last_rdata, last_rresp}), 80'({64'h0, 2'b11}));
`else
      chk("wrap_read", 80'({last_rdata, last_rresp}), 80'({64'h12345678_9ABCDEF0, 2'b00}));
`endif

      repeat (4) @(posedge aclk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nasti_mem_responder.md
NASTI_MEM_RESPONDER -- requirements
Module: nasti_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: AXI address width.
REQ-002 Parameter DATA_WIDTH, default 64: data bus width; beat = DATA_WIDTH/8 bytes.
REQ-003 Parameter MEM_BYTES, default 65536: backing-store size; power of two, multiple of beat size.
REQ-004 Port aclk, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port areset, input, 1: synchronous, active-high reset.
REQ-006 Port slv, nasti_channel (responder side), -: AXI4 responder end.
- Driven: aw_ready, w_ready, b_valid/b_id/b_resp, ar_ready, r_valid/r_id/r_data/r_resp/r_last.
- Sampled: all other slv fields.

Function
REQ-007 Independent write FSM and read FSM; one outstanding transaction per direction.
REQ-008 Write FSM SHALL have states W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
- aw_ready=1 only in W_IDLE.
- AW handshake latches aw_id, aw_len, and aw_addr with the low log2(beat) bits forced to zero; moves to W_DATA.
REQ-009 W_DATA: w_ready=1.
- Each W handshake writes the bytes enabled by w_strb at the current address, then advances the address by one beat.
- Beat counter increments per beat.
REQ-010 W handshake with w_last=1 SHALL move to W_RESP.
- b_resp=OKAY (2'b00) if beat count equals aw_len+1; otherwise SLVERR (2'b10).
- Beats after aw_len+1 without w_last are written anyway (address keeps incrementing).
REQ-011 W_RESP: b_valid=1, b_id=latched id, held stable until b_ready; B handshake returns to W_IDLE the next cycle.
REQ-012 Read FSM SHALL have states R_IDLE -> R_DATA -> R_IDLE.
- ar_ready=1 only in R_IDLE.
- AR handshake latches ar_id, ar_len and the aligned ar_addr.
REQ-013 Memory read latency is one cycle: AR handshake at edge N -> r_valid=1 after edge N+1 with beat 0 data.
REQ-014 Under backpressure (r_valid=1, r_ready=0), r_data/r_last/r_id/r_resp SHALL be held stable.
REQ-015 Back-to-back beats: with r_ready held high, one beat per cycle, no bubbles.
REQ-016 r_last=1 exactly on beat ar_len; R handshake on that beat returns to R_IDLE; r_valid=0 the next cycle unless a new burst is already loaded.
REQ-017 ar_burst/aw_burst: all encodings treated as INCR. ar_size/aw_size ignored; full-width beats assumed.
REQ-018 Same-cycle read and write to the same word: read returns the old data (read-before-write).
REQ-019 Address beyond MEM_BYTES: behaviour per REQ-023/REQ-024.
REQ-020 Read and write FSMs SHALL never block each other.

Reset
REQ-021 With areset high at a clock edge:
- aw_ready=1, ar_ready=1; w_ready=0, b_valid=0, r_valid=0, r_last=0; b_resp=0, r_resp=0.
- Both FSMs return to idle.
REQ-022 Reset mid-burst SHALL abandon the burst; no B or R response is issued for it. Memory contents are not reset.

Configuration
REQ-023 With NASTI_MEM_RESP_ERR_EN defined, any beat whose address is >= MEM_BYTES:
- write: dropped; b_resp=DECERR (2'b11) unless SLVERR already applies.
- read: returns r_data=0, r_resp=DECERR for that beat.
REQ-024 Without NASTI_MEM_RESP_ERR_EN, addresses wrap modulo MEM_BYTES and all responses are OKAY except the SLVERR of REQ-010.

Verification
REQ-025 Single beat: AW addr=0x100 len=0 id=3, W data=0xDEADBEEF_CAFEF00D strb=0xFF last=1 -> b_resp=0, b_id=3; AR 0x100 -> r_data=0xDEADBEEF_CAFEF00D, r_last=1, r_id=3.
REQ-026 Burst: write len=255 at 0x0, data=beat index; read back with r_ready toggled every other cycle -> 256 beats in order, r_last only on beat 255, data stable during stalls.
REQ-027 Strobe: pre-fill 0x40 with all ones; write 0 with strb=0x0F -> read 0x40 returns 0xFFFFFFFF_00000000.
REQ-028 Length mismatch: AW len=3, w_last on beat 2 -> b_resp=2'b10 after beat 2.
REQ-029 Reset mid-burst: reset asserted during read beat 5 of len=15 -> r_valid=0 next cycle, ar_ready=1; a fresh read then completes normally.
REQ-030 With NASTI_MEM_RESP_ERR_EN, AR addr=MEM_BYTES -> r_resp=2'b11, r_data=0; without it, the same read returns the data stored at 0x0.
